// File: rtl/uart_hd_fifo.sv
// rtl/uart_hd_fifo.sv - half-duplex open-drain UART PHY with TX/RX FIFOs for a UPDI line
// RX is held idle whenever TX is active, so the local echo on the shared line is never received.

module uart_hd_fifo_q #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_ok, rd_ok;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_ok && !rd_ok)      count_q <= count_q + (AW+1)'(1);
      else if (rd_ok && !wr_ok) count_q <= count_q - (AW+1)'(1);
    end
  end
endmodule

module uart_hd_fifo #(
  parameter int    DATA_BITS   = 8,
  parameter string PARITY_MODE = "even",
  parameter int    STOP_BITS   = 2,
  parameter int    FIFO_DEPTH  = 16,
  parameter int    DIV_W       = 16,
  parameter int    GUARD_BITS  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [DATA_BITS-1:0]          tx_data_i,
  input  logic                          tx_fifo_wr_en_i,
  output logic                          tx_fifo_full_o,
  output logic                          tx_fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count_o,
  output logic [DATA_BITS-1:0]          rx_data_o,
  input  logic                          rx_fifo_rd_en_i,
  output logic                          rx_fifo_full_o,
  output logic                          rx_fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count_o,
  input  logic                          send_break_i,
  output logic                          break_detected_o,
  input  logic                          err_clr_i,
  output logic                          rx_parity_err_o,
  output logic                          rx_frame_err_o,
  output logic                          rx_overflow_o,
  output logic                          tx_collision_o,
  output logic                          busy_o,
  input  logic                          line_in_i,
  output logic                          line_drive_low_o
);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam bit HAS_PAR    = (PARITY_MODE != "none");
  localparam bit ODD        = (PARITY_MODE == "odd");
  localparam int FRAME_BITS = 1 + DATA_BITS + (HAS_PAR ? 1 : 0) + STOP_BITS;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_GUARD, TX_BREAK} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
  logic [7:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, tx_head;
  logic                 tx_par_q, tx_par_d, tx_pop, tx_bit_end, tx_mid;
  logic                 brk_pend_q, brk_pend_d, brk_block, coll_q, coll_d;
  logic [CW-1:0]        brk_left_q, brk_left_d;

  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_W-1:0]     rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d, rx_zero_q, rx_zero_d, rx_push, line_prev_q;
  logic                 brk_det_q, brk_det_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  uart_hd_fifo_q #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(tx_fifo_wr_en_i), .wr_data_i(tx_data_i),
    .rd_en_i(tx_pop), .rd_data_o(tx_head), .full_o(tx_fifo_full_o),
    .empty_o(tx_fifo_empty_o), .count_o(tx_fifo_count_o));

  uart_hd_fifo_q #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(rx_push), .wr_data_i(rx_shift_q),
    .rd_en_i(rx_fifo_rd_en_i), .rd_data_o(rx_data_o), .full_o(rx_fifo_full_o),
    .empty_o(rx_fifo_empty_o), .count_o(rx_fifo_count_o));

  assign tx_bit_end = (tx_cnt_q == tx_div_q);
  assign tx_mid     = (tx_cnt_q == (tx_div_q >> 1));
  // A pending break blocks further pops once every byte queued ahead of it has left.
  assign brk_block  = brk_pend_q && (brk_left_q == '0);
  assign busy_o     = (tx_state_q != TX_IDLE) || !tx_fifo_empty_o;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q + DIV_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (brk_block) begin
          tx_state_d = TX_BREAK;
          tx_div_d   = baud_div_i;
          tx_bit_d   = '0;
        end else if (!tx_fifo_empty_o) tx_pop = 1'b1;
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 8'd1;
        if (tx_bit_q == 8'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 8'd1;
        if (tx_bit_q == 8'(STOP_BITS - 1)) begin
          tx_bit_d = '0;
          if (!tx_fifo_empty_o && !brk_block) tx_pop = 1'b1;
          else tx_state_d = TX_GUARD;
        end
      end
      TX_GUARD: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 8'd1;
        if (tx_bit_q == 8'(GUARD_BITS - 1)) tx_state_d = TX_IDLE;
      end
      TX_BREAK: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 8'd1;
        if (tx_bit_q == 8'(2 * FRAME_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = TX_GUARD;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_state_d = TX_START;
      tx_div_d   = baud_div_i;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ ODD;
    end
  end

  always_comb begin
    brk_pend_d = brk_pend_q;
    brk_left_d = brk_left_q;
    if (brk_pend_q && tx_pop && (brk_left_q != '0)) brk_left_d = brk_left_q - CW'(1);
    if ((tx_state_q == TX_IDLE) && brk_block) brk_pend_d = 1'b0;
    if (send_break_i && !brk_pend_q) begin
      brk_pend_d = 1'b1;
      brk_left_d = tx_fifo_count_o - CW'(tx_pop);
    end
  end

  always_comb begin
    line_drive_low_o = 1'b0;
    unique case (tx_state_q)
      TX_START, TX_BREAK: line_drive_low_o = 1'b1;
      TX_DATA:            line_drive_low_o = !tx_shift_q[0];
      TX_PARITY:          line_drive_low_o = !tx_par_q;
      default:            line_drive_low_o = 1'b0;
    endcase
  end

  // Collision: line level at mid-bit should equal the level we drive (released = high).
  assign coll_d = ((tx_state_q inside {TX_START, TX_DATA, TX_PARITY, TX_STOP}) && tx_mid &&
                   (line_in_i == line_drive_low_o)) || (coll_q && !err_clr_i);
  assign tx_collision_o = coll_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      brk_pend_q <= 1'b0;
      brk_left_q <= '0;
      coll_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      brk_pend_q <= brk_pend_d;
      brk_left_q <= brk_left_d;
      coll_q     <= coll_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q + DIV_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_zero_d  = rx_zero_q;
    rx_push    = 1'b0;
    brk_det_d  = 1'b0;
    perr_d     = perr_q && !err_clr_i;
    ferr_d     = ferr_q && !err_clr_i;
    ovf_d      = ovf_q && !err_clr_i;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (line_prev_q && !line_in_i) begin
          rx_state_d = RX_START;
          rx_div_d   = baud_div_i;
          rx_bit_d   = '0;
          rx_zero_d  = 1'b1;
          rx_par_d   = 1'b0;
        end
      end
      RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
        rx_cnt_d   = '0;
        rx_state_d = line_in_i ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d   = '0;
        rx_shift_d = {line_in_i, rx_shift_q[DATA_BITS-1:1]};
        rx_zero_d  = rx_zero_q && !line_in_i;
        rx_bit_d   = rx_bit_q + 8'd1;
        if (rx_bit_q == 8'(DATA_BITS - 1)) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d   = '0;
        rx_par_d   = line_in_i;
        rx_zero_d  = rx_zero_q && !line_in_i;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d = '0;
        if (line_in_i) begin
          rx_state_d = RX_IDLE;
          if (rx_fifo_full_o) ovf_d = 1'b1;
          else rx_push = 1'b1;
          if (HAS_PAR && ((^rx_shift_q) ^ rx_par_q ^ ODD)) perr_d = 1'b1;
        end else begin
          rx_state_d = RX_WAIT_HIGH;
          if (rx_zero_q) brk_det_d = 1'b1;
          else ferr_d = 1'b1;
        end
      end
      RX_WAIT_HIGH: if (line_in_i) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    if (tx_state_q != TX_IDLE) rx_state_d = RX_IDLE;
  end

  assign break_detected_o = brk_det_q;
  assign rx_parity_err_o  = perr_q;
  assign rx_frame_err_o   = ferr_q;
  assign rx_overflow_o    = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q  <= RX_IDLE;
      rx_div_q    <= '0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_par_q    <= 1'b0;
      rx_zero_q   <= 1'b0;
      line_prev_q <= 1'b1;
      brk_det_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_div_q    <= rx_div_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_par_q    <= rx_par_d;
      rx_zero_q   <= rx_zero_d;
      line_prev_q <= line_in_i;
      brk_det_q   <= brk_det_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_hd_fifo.sv
// tb/tb_uart_hd_fifo.sv - directed bench for uart_hd_fifo, 8E2, baud_div=9
// Line is modelled as wired-AND of the remote sender, the DUT driver and a fault injector.

module tb_uart_hd_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd9;
  logic [7:0]  tx_data = '0;
  logic        tx_wr = 1'b0;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [4:0]  tx_count, rx_count;
  logic [7:0]  rx_data;
  logic        rx_rd = 1'b0;
  logic        send_break = 1'b0;
  logic        break_detected;
  logic        err_clr = 1'b0;
  logic        perr, ferr, ovf, coll, busy;
  logic        line_in, line_drive_low;
  logic        remote_line = 1'b1;
  logic        force_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int brk_pulses = 0;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       clr_after;
    logic       exp_perr;
  } rx_vec_t;
  rx_vec_t rx_tab[5];

  assign line_in = remote_line & ~line_drive_low & ~force_low;

  uart_hd_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div),
    .tx_data_i(tx_data), .tx_fifo_wr_en_i(tx_wr), .tx_fifo_full_o(tx_full),
    .tx_fifo_empty_o(tx_empty), .tx_fifo_count_o(tx_count),
    .rx_data_o(rx_data), .rx_fifo_rd_en_i(rx_rd), .rx_fifo_full_o(rx_full),
    .rx_fifo_empty_o(rx_empty), .rx_fifo_count_o(rx_count),
    .send_break_i(send_break), .break_detected_o(break_detected), .err_clr_i(err_clr),
    .rx_parity_err_o(perr), .rx_frame_err_o(ferr), .rx_overflow_o(ovf),
    .tx_collision_o(coll), .busy_o(busy), .line_in_i(line_in),
    .line_drive_low_o(line_drive_low));

  always #5 clk = ~clk;
  always @(negedge clk) if (break_detected) brk_pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_wr = 1'b1;
    tick(1);
    tx_wr = 1'b0;
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    remote_line = v;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((^b) ^ bad_par);
    send_bit(~bad_stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n, run, brk_run, p0;
    rx_tab[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    rx_tab[1] = '{8'h3C, 1'b1, 1'b1, 1'b1};
    rx_tab[2] = '{8'h00, 1'b0, 1'b0, 1'b0};
    rx_tab[3] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    rx_tab[4] = '{8'h81, 1'b0, 1'b1, 1'b1};

    tick(3);
    check("reset_line_drive_low", line_drive_low, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_count", tx_count, 0);
    check("reset_rx_empty", rx_empty, 1);
    check("reset_flags", {perr, ferr, ovf, coll, break_detected}, 0);
    rst_n = 1'b1;
    tick(3);

    // Loopback, 15 back-to-back frames
    for (int i = 0; i < 15; i++) push(8'(i));
    check("loopback_busy", busy, 1);
    wait_idle(3000, n);
    check("loopback_idle", busy, 0);
    check("loopback_cycles_in_window", (n >= 1805 && n <= 1809), 1);
    check("loopback_collision", coll, 0);
    check("loopback_echo_suppressed", rx_count, 0);

    // Remote sender vectors
    foreach (rx_tab[k]) begin
      send_byte(rx_tab[k].data, rx_tab[k].bad_par, 1'b0);
      n = 0;
      while (rx_empty && n < 50) begin
        tick(1);
        n++;
      end
      check($sformatf("rx%0d_data", k), rx_data, rx_tab[k].data);
      check($sformatf("rx%0d_count", k), rx_count, 1);
      check($sformatf("rx%0d_parity_err", k), perr, rx_tab[k].exp_perr);
      check($sformatf("rx%0d_frame_err", k), ferr, 0);
      pop();
      if (rx_tab[k].clr_after) begin
        pulse_clr();
        check($sformatf("rx%0d_parity_err_cleared", k), perr, 0);
      end
    end

    // Framing error: first stop bit low with nonzero data
    send_byte(8'h5A, 1'b0, 1'b1);
    check("frame_err_set", ferr, 1);
    check("frame_err_no_push", rx_count, 0);
    pulse_clr();
    check("frame_err_cleared", ferr, 0);

    // BREAK queued behind three bytes
    p0 = brk_pulses;
    push(8'h55);
    push(8'hAA);
    push(8'h0F);
    send_break = 1'b1;
    tick(1);
    send_break = 1'b0;
    run = 0;
    brk_run = 0;
    n = 0;
    while (brk_run == 0 && n < 1500) begin
      tick(1);
      n++;
      if (line_drive_low) begin
        run++;
        if (run == 130) check("break_after_frames_fifo_empty", tx_empty, 1);
      end else begin
        if (run > 130) brk_run = run;
        run = 0;
      end
    end
    check("break_low_clocks", brk_run, 240);
    wait_idle(200, n);
    check("break_idle", busy, 0);
    check("break_echo_suppressed", brk_pulses - p0, 0);
    check("break_no_rx", rx_count, 0);

    // Remote BREAK: 24 bit times low
    p0 = brk_pulses;
    remote_line = 1'b0;
    tick(240);
    remote_line = 1'b1;
    tick(30);
    check("remote_break_pulses", brk_pulses - p0, 1);
    check("remote_break_no_push", rx_count, 0);
    check("remote_break_no_frame_err", ferr, 0);

    // Collision on a data bit of 1, then a second queued byte
    push(8'h01);
    push(8'h02);
    check("start_latency_drive_low", line_drive_low, 1);
    tick(11);
    force_low = 1'b1;
    tick(7);
    force_low = 1'b0;
    check("collision_set", coll, 1);
    wait_idle(500, n);
    check("collision_idle", busy, 0);
    check("collision_second_frame_sent", (n >= 240 && n <= 244), 1);
    check("collision_sticky", coll, 1);
    pulse_clr();
    check("collision_cleared", coll, 0);

    // RX overflow: 17 bytes, no reads
    for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0);
    check("ovf_full", rx_full, 1);
    check("ovf_count", rx_count, 16);
    check("ovf_flag", ovf, 1);
    check("ovf_head", rx_data, 8'h10);
    check("ovf_parity_ok", perr, 0);
    pop();
    check("ovf_next_head", rx_data, 8'h11);
    check("ovf_count_after_pop", rx_count, 15);

    // Asynchronous reset in the middle of a START bit
    push(8'h5A);
    tick(3);
    check("mid_start_drive_low", line_drive_low, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_release", line_drive_low, 0);
    check("async_reset_tx_count", tx_count, 0);
    check("async_reset_rx_count", rx_count, 0);
    check("async_reset_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("post_reset_flags", {perr, ferr, ovf, coll}, 0);
    check("post_reset_line", line_drive_low, 0);
    check("post_reset_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
